// File: rtl/ps_kernel_control_pkg.sv
// Shared widths and read-FSM state type for the 3x3 kernel window generator.
package ps_kernel_control_pkg;

  localparam int PIX_W    = 8;
  localparam int ROW_W    = 3 * PIX_W;
  localparam int KERNEL_W = 72;

  typedef enum logic {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

endpackage

// File: rtl/ps_linebuffer.sv
// One image line of storage; each read returns {left, centre, right} around the
// read pointer one cycle later. Pointers reset, memory contents do not.
module ps_linebuffer
  import ps_kernel_control_pkg::*;
#(
  parameter int LINE_LENGTH = 640
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_wr,
  input  logic [PIX_W-1:0] i_data,
  input  logic             i_rd,
  output logic [ROW_W-1:0] o_data
);
  localparam int PTR_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(LINE_LENGTH - 1);

  logic [PIX_W-1:0] mem [LINE_LENGTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_prev, rd_next;

  // Neighbour taps wrap around the line ends; the caller decides what edges mean.
  assign rd_prev = (rd_ptr == '0) ? PTR_LAST : rd_ptr - PTR_W'(1);
  assign rd_next = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_W'(1);

  always_ff @(posedge i_clk) begin
    if (i_wr) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_data <= '0;
    end else begin
      if (i_wr) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_W'(1);
      if (i_rd) begin
        rd_ptr <= rd_next;
        o_data <= {mem[rd_prev], mem[rd_ptr], mem[rd_next]};
      end
    end
  end

endmodule

// File: rtl/ps_kernel_control.sv
// 3x3 pixel window generator over a ring of four line buffers.
// Optional build macro PS_KERNEL_EDGE_ZERO_EN zeroes the off-image taps at line ends.
module ps_kernel_control
  import ps_kernel_control_pkg::*;
#(
  parameter int LINE_LENGTH = 640
) (
  input  logic                i_clk,
  input  logic                i_rstn,
  input  logic                i_valid,
  input  logic [PIX_W-1:0]    i_data,
  output logic                o_ready,
  output logic [KERNEL_W-1:0] o_kernel,
  output logic                o_valid,
  output logic                o_ovf
);
  localparam int CNT_W = $clog2(4 * LINE_LENGTH + 1);
  localparam int COL_W = (LINE_LENGTH > 1) ? $clog2(LINE_LENGTH) : 1;
  localparam logic [CNT_W-1:0] LINE_CNT = CNT_W'(LINE_LENGTH);
  localparam logic [CNT_W-1:0] RD_LVL   = CNT_W'(3 * LINE_LENGTH);
  localparam logic [CNT_W-1:0] FULL_LVL = CNT_W'(4 * LINE_LENGTH);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_LENGTH - 1);

  state_t              state, state_nxt;
  logic [1:0]          wr_sel, rd_sel, sel_p1;
  logic [COL_W-1:0]    wr_col, rd_col;
  logic [CNT_W-1:0]    fill_count;
  logic                wr_en, rd_en, rd_done;
  logic [3:0]          buf_wr, buf_rd;
  logic [ROW_W-1:0]    buf_data [4];
  logic                vld_p1, ovf_p1;
  logic [KERNEL_W-1:0] kernel;

  // The writer can only reach the buffer that is not being read while fill < 4 lines.
  assign o_ready = (fill_count < FULL_LVL);
  assign wr_en   = i_valid & o_ready;
  assign rd_en   = (state == READ);
  assign rd_done = rd_en && (rd_col == COL_LAST);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_sel <= '0;
      wr_col <= '0;
    end else if (wr_en) begin
      wr_col <= (wr_col == COL_LAST) ? '0 : wr_col + COL_W'(1);
      if (wr_col == COL_LAST) wr_sel <= wr_sel + 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fill_count >= RD_LVL) state_nxt = READ;
      READ: if (rd_col == COL_LAST) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state      <= IDLE;
      rd_col     <= '0;
      rd_sel     <= '0;
      fill_count <= '0;
    end else begin
      state <= state_nxt;
      if (rd_en) rd_col <= rd_done ? '0 : rd_col + COL_W'(1);
      if (rd_done) rd_sel <= rd_sel + 2'd1;
      case ({wr_en, rd_done})
        2'b10:   fill_count <= fill_count + CNT_W'(1);
        2'b01:   fill_count <= fill_count - LINE_CNT;
        2'b11:   fill_count <= fill_count + CNT_W'(1) - LINE_CNT;
        default: fill_count <= fill_count;
      endcase
    end
  end

  always_comb begin
    buf_wr = '0;
    buf_rd = '0;
    for (int i = 0; i < 4; i++) begin
      buf_wr[i] = wr_en && (wr_sel == 2'(i));
      buf_rd[i] = rd_en && ((2'(i) - rd_sel) != 2'd3);
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_lb
    ps_linebuffer #(.LINE_LENGTH(LINE_LENGTH)) u_lb (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_wr   (buf_wr[g]),
      .i_data (i_data),
      .i_rd   (buf_rd[g]),
      .o_data (buf_data[g])
    );
  end

  // Stage p1: line-buffer read data lands; row mapping follows the burst's rd_sel.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_p1 <= 1'b0;
      ovf_p1 <= 1'b0;
      sel_p1 <= '0;
    end else begin
      vld_p1 <= rd_en;
      ovf_p1 <= i_valid & ~o_ready;
      if (rd_en) sel_p1 <= rd_sel;
    end
  end

`ifdef PS_KERNEL_EDGE_ZERO_EN
  logic [COL_W-1:0] col_p1;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) col_p1 <= '0;
    else if (rd_en) col_p1 <= rd_col;
  end
`endif

  always_comb begin
    kernel = {buf_data[sel_p1], buf_data[sel_p1 + 2'd1], buf_data[sel_p1 + 2'd2]};
`ifdef PS_KERNEL_EDGE_ZERO_EN
    for (int r = 0; r < 3; r++) begin
      if (col_p1 == '0) kernel[KERNEL_W-1-r*ROW_W -: PIX_W] = '0;
      if (col_p1 == COL_LAST) kernel[PIX_W-1+(2-r)*ROW_W -: PIX_W] = '0;
    end
`endif
  end

  assign o_kernel = kernel;
  assign o_valid  = vld_p1;
  assign o_ovf    = ovf_p1;

endmodule

// File: tb/tb_ps_kernel_control.sv
// Directed bench for ps_kernel_control at LINE_LENGTH=8, pixel = 16*line + column.
module tb_ps_kernel_control;
  import ps_kernel_control_pkg::*;

  localparam int L = 8;
  localparam logic [71:0] ALL = {72{1'b1}};

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_valid = 1'b0;
  logic [7:0]  i_data = '0;
  logic        o_ready;
  logic [71:0] o_kernel;
  logic        o_valid;
  logic        o_ovf;

  ps_kernel_control #(.LINE_LENGTH(L)) dut (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .o_ready  (o_ready),
    .o_kernel (o_kernel),
    .o_valid  (o_valid),
    .o_ovf    (o_ovf)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Output monitor: sorts o_valid cycles into bursts and columns.
  int          n_burst = 0, n_valid = 0, n_ovf = 0, cur_col = 0;
  logic        prev_v = 1'b0;
  logic [71:0] cap [16][8];
  int          blen [16] = '{default: 0};

  always @(negedge i_clk) begin
    if (o_ovf) n_ovf++;
    if (o_valid) begin
      if (!prev_v) begin
        n_burst++;
        cur_col = 0;
      end
      if (n_burst >= 1 && n_burst <= 16) begin
        if (cur_col < 8) cap[n_burst-1][cur_col] = o_kernel;
        blen[n_burst-1]++;
      end
      cur_col++;
      n_valid++;
    end
    prev_v = o_valid;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    int          burst;
    int          col;
    logic [71:0] exp;
    logic [71:0] mask;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [7:0] pix(int p);
    return 8'(16 * (p / L) + (p % L));
  endfunction

  // Expected window with top row on line 'top'; taps outside the line read as 0.
  function automatic logic [71:0] model_kernel(int top, int k);
    logic [71:0] kv = '0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        int col;
        col = k - 1 + c;
        kv[71 - (r*24 + c*8) -: 8] = (col < 0 || col >= L) ? 8'h00 : 8'(16*(top+r) + col);
      end
    end
    return kv;
  endfunction

  function automatic logic [71:0] edge_mask(int k);
    logic [71:0] m = ALL;
`ifndef PS_KERNEL_EDGE_ZERO_EN
    for (int r = 0; r < 3; r++) begin
      if (k == 0) m[71 - r*24 -: 8] = '0;
      if (k == L-1) m[7 + (2-r)*24 -: 8] = '0;
    end
`endif
    return m;
  endfunction

  task automatic check_k(input string name, input logic [71:0] act, input logic [71:0] exp,
                         input logic [71:0] mask);
    n_tests++;
    if (((act ^ exp) & mask) !== 72'd0) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (mask %h)", name, act, exp, mask);
    end
  endtask

  task automatic check_i(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    i_valid = v;
    i_data  = d;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_data  = '0;
    i_rstn  = 1'b0;
    repeat (2) @(posedge i_clk);
    #3 i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int base_b, base_v, base_o, p, guard;
    logic rdy;

    // Reset values, observed while reset is held.
    #3;
    check_i("rst_ready", int'(o_ready), 1);
    check_i("rst_valid", int'(o_valid), 0);
    check_i("rst_ovf", int'(o_ovf), 0);
    check_k("rst_kernel", o_kernel, 72'd0, ALL);
    do_reset();

    // Continuous stream of six lines; the source only pauses while o_ready is low.
    base_b = n_burst; base_v = n_valid; base_o = n_ovf;
    for (int i = 0; i < 23; i++) step(1'b1, pix(i));
    check_i("fill_23", int'(dut.fill_count), 23);
    check_i("no_valid_23", n_valid - base_v, 0);
    step(1'b1, pix(23));
    check_i("idle_at_24", int'(dut.state), int'(IDLE));
    step(1'b1, pix(24));
    check_i("read_entry", int'(dut.state), int'(READ));
    check_i("valid_lat0", int'(o_valid), 0);
    step(1'b1, pix(25));
    check_i("valid_lat1", int'(o_valid), 1);
    p = 26; guard = 0;
    while (p < 6*L && guard < 400) begin
      rdy = o_ready;
      step(rdy, pix(p));
      if (rdy) p++;
      guard++;
    end
    check_i("stream_done", p, 6*L);
    step(1'b0, 8'h00);
    repeat (30) step(1'b0, 8'h00);
    check_i("bursts_6lines", n_burst - base_b, 4);
    check_i("valids_6lines", n_valid - base_v, 32);
    check_i("ovf_6lines", n_ovf - base_o, 0);
    for (int b = 0; b < 4; b++) check_i($sformatf("burst%0d_len", b), blen[base_b + b], 8);

    tbl.push_back('{"b1_k3", 0, 3, 72'h020304_121314_222324, ALL});
    tbl.push_back('{"b4_k0_mid", 3, 0, 72'h000000_004000_000000, 72'h000000_00ff00_000000});
`ifdef PS_KERNEL_EDGE_ZERO_EN
    tbl.push_back('{"b1_k0_edge", 0, 0, 72'h000001_001011_002021, ALL});
    tbl.push_back('{"b1_k7_right", 0, 7, 72'd0, 72'h0000ff_0000ff_0000ff});
`endif
    for (int b = 0; b < 4; b++)
      for (int k = 0; k < L; k++)
        tbl.push_back('{$sformatf("b%0d_k%0d", b + 1, k), b, k, model_kernel(b, k), edge_mask(k)});
    foreach (tbl[i])
      check_k(tbl[i].name, cap[base_b + tbl[i].burst][tbl[i].col], tbl[i].exp, tbl[i].mask);

    // Source ignores o_ready: the 33rd pixel meets a full ring and is dropped.
    do_reset();
    for (int i = 0; i < 32; i++) step(1'b1, pix(i));
    check_i("fill_32", int'(dut.fill_count), 32);
    check_i("ready_full", int'(o_ready), 0);
    step(1'b1, 8'hee);
    check_i("ovf_pulse", int'(o_ovf), 1);
    check_i("fill_after_drop", int'(dut.fill_count), 24);
    step(1'b0, 8'h00);
    check_i("ovf_one_cycle", int'(o_ovf), 0);
    check_i("ready_again", int'(o_ready), 1);

    // Reset in the 4th READ cycle, then a fresh frame.
    do_reset();
    for (int i = 0; i < 24; i++) step(1'b1, pix(i));
    step(1'b0, 8'h00);
    check_i("abort_read_entry", int'(dut.state), int'(READ));
    repeat (3) step(1'b0, 8'h00);
    check_i("abort_pre_valid", int'(o_valid), 1);
    #2 i_rstn = 1'b0;
    #1;
    check_i("abort_valid", int'(o_valid), 0);
    check_i("abort_ready", int'(o_ready), 1);
    check_k("abort_kernel", o_kernel, 72'd0, ALL);
    repeat (2) @(posedge i_clk);
    #3 i_rstn = 1'b1;
    base_b = n_burst; base_v = n_valid;
    repeat (12) step(1'b0, 8'h00);
    check_i("abort_no_valid", n_valid - base_v, 0);
    for (int i = 0; i < 24; i++) step(1'b1, pix(i));
    repeat (14) step(1'b0, 8'h00);
    check_i("restart_bursts", n_burst - base_b, 1);
    check_i("restart_len", blen[base_b], 8);
    for (int k = 0; k < L; k++)
      check_k($sformatf("restart_k%0d", k), cap[base_b][k], model_kernel(0, k), edge_mask(k));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
